// File: rtl/nand_page_address_counter_if.sv
// Control/status bus between the NAND controller FSM (master) and the page address counter (slave).
// The cfg_err status line exists only when ADDR_RANGE_CHECK_EN is defined.
interface nand_page_address_counter_if #(
  parameter int COL_BITS = 12,
  parameter int ROW_BITS = 17
);
  logic                clear;
  logic                load;
  logic                count_enable;
  logic [COL_BITS-1:0] start_col;
  logic [COL_BITS-1:0] end_col;
  logic [ROW_BITS-1:0] start_row;
  logic [ROW_BITS-1:0] end_row;
  logic [COL_BITS-1:0] col_addr;
  logic [ROW_BITS-1:0] row_addr;
  logic                col_reached;
  logic                page_done;
  logic                xfer_done;
  logic                busy;
`ifdef ADDR_RANGE_CHECK_EN
  logic                cfg_err;
`endif

  modport master (
    output clear, load, count_enable, start_col, end_col, start_row, end_row,
    input  col_addr, row_addr, col_reached, page_done, xfer_done, busy
`ifdef ADDR_RANGE_CHECK_EN
    , input cfg_err
`endif
  );

  modport slave (
    input  clear, load, count_enable, start_col, end_col, start_row, end_row,
    output col_addr, row_addr, col_reached, page_done, xfer_done, busy
`ifdef ADDR_RANGE_CHECK_EN
    , output cfg_err
`endif
  );
endinterface

// File: rtl/nand_page_address_counter.sv
// Column/row address generator for NAND page transfers: walks start_col..end_col per page, start_row..end_row per run.
// Optional ADDR_RANGE_CHECK_EN rejects loads with an out-of-range or inverted configuration and flags cfg_err.
module nand_page_address_counter #(
  parameter int PAGE_SIZE = 2112,
  parameter int COL_BITS  = $clog2(PAGE_SIZE),
  parameter int ROW_BITS  = 17
) (
  input  logic clk2,
  input  logic NReset,
  nand_page_address_counter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  logic [COL_BITS-1:0] start_col_r;
  logic [COL_BITS-1:0] end_col_r;
  logic [ROW_BITS-1:0] start_row_r;
  logic [ROW_BITS-1:0] end_row_r;

  logic [COL_BITS-1:0] col_addr_r;
  logic [ROW_BITS-1:0] row_addr_r;
  logic                page_done_r;
  logic                xfer_done_r;
  logic                busy_r;

  logic [COL_BITS-1:0] col_nxt_s;
  logic [ROW_BITS-1:0] row_nxt_s;
  logic                page_done_nxt_s;
  logic                xfer_done_nxt_s;

  logic                cfg_bad_s;
  logic                load_ok_s;
  logic                at_end_col_s;
  logic                at_end_row_s;
  logic                step_s;

`ifdef ADDR_RANGE_CHECK_EN
  localparam logic [COL_BITS:0] PAGE_LIMIT = (COL_BITS+1)'(PAGE_SIZE);

  logic cfg_err_r;
  logic cfg_err_nxt_s;

  assign cfg_bad_s = (bus.start_col > bus.end_col)
                  || ({1'b0, bus.end_col} >= PAGE_LIMIT)
                  || (bus.start_row > bus.end_row);
  assign bus.cfg_err = cfg_err_r;
`else
  assign cfg_bad_s = 1'b0;
`endif

  // A load is only honoured outside RUN and (when checked) with a sane configuration.
  assign load_ok_s    = bus.load && (state_r != ST_RUN) && !cfg_bad_s;
  assign at_end_col_s = (col_addr_r == end_col_r);
  assign at_end_row_s = (row_addr_r == end_row_r);
  assign step_s       = (state_r == ST_RUN) && bus.count_enable;

  // State register
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: clear beats load beats count_enable
  always_comb begin
    state_nxt_s = state_r;
    if (bus.clear) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = load_ok_s ? ST_RUN : ST_IDLE;
        ST_RUN:  state_nxt_s = (step_s && at_end_col_s && at_end_row_s) ? ST_DONE : ST_RUN;
        ST_DONE: state_nxt_s = load_ok_s ? ST_RUN : ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered address/flag outputs
  always_comb begin
    col_nxt_s       = col_addr_r;
    row_nxt_s       = row_addr_r;
    page_done_nxt_s = 1'b0;
    xfer_done_nxt_s = xfer_done_r;
    if (bus.clear) begin
      col_nxt_s       = '0;
      row_nxt_s       = '0;
      xfer_done_nxt_s = 1'b0;
    end else if (load_ok_s) begin
      col_nxt_s       = bus.start_col;
      row_nxt_s       = bus.start_row;
      xfer_done_nxt_s = 1'b0;
    end else if (step_s) begin
      if (!at_end_col_s) begin
        col_nxt_s = col_addr_r + COL_BITS'(1);
      end else if (!at_end_row_s) begin
        col_nxt_s       = start_col_r;
        row_nxt_s       = row_addr_r + ROW_BITS'(1);
        page_done_nxt_s = 1'b1;
      end else begin
        page_done_nxt_s = 1'b1;
        xfer_done_nxt_s = 1'b1;
      end
    end else begin
      page_done_nxt_s = 1'b0;
    end
  end

`ifdef ADDR_RANGE_CHECK_EN
  // Next value of the configuration error flag; a load in RUN leaves it untouched
  always_comb begin
    cfg_err_nxt_s = cfg_err_r;
    if (bus.clear) begin
      cfg_err_nxt_s = 1'b0;
    end else if (bus.load && (state_r != ST_RUN)) begin
      cfg_err_nxt_s = cfg_bad_s;
    end else begin
      cfg_err_nxt_s = cfg_err_r;
    end
  end

  // Configuration error register
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_err_nxt_s;
    end
  end
`endif

  // Output and latched-configuration registers; clear leaves the latched configuration alone
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      col_addr_r  <= '0;
      row_addr_r  <= '0;
      page_done_r <= 1'b0;
      xfer_done_r <= 1'b0;
      busy_r      <= 1'b0;
      start_col_r <= '0;
      end_col_r   <= '0;
      start_row_r <= '0;
      end_row_r   <= '0;
    end else begin
      col_addr_r  <= col_nxt_s;
      row_addr_r  <= row_nxt_s;
      page_done_r <= page_done_nxt_s;
      xfer_done_r <= xfer_done_nxt_s;
      busy_r      <= (state_nxt_s == ST_RUN);
      if (!bus.clear && load_ok_s) begin
        start_col_r <= bus.start_col;
        end_col_r   <= bus.end_col;
        start_row_r <= bus.start_row;
        end_row_r   <= bus.end_row;
      end
    end
  end

  assign bus.col_addr    = col_addr_r;
  assign bus.row_addr    = row_addr_r;
  assign bus.page_done   = page_done_r;
  assign bus.xfer_done   = xfer_done_r;
  assign bus.busy        = busy_r;
  assign bus.col_reached = (state_r == ST_RUN) && at_end_col_s;

endmodule

// File: tb/tb_nand_page_address_counter.sv
// Self-checking bench for nand_page_address_counter: byte-count model plus directed vectors.
// Build with ADDR_RANGE_CHECK_EN defined to also exercise cfg_err.
module tb_nand_page_address_counter;
  localparam int CB = 12;
  localparam int RB = 17;

  logic clk2   = 1'b0;
  logic NReset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk2 = ~clk2;

  nand_page_address_counter_if #(.COL_BITS(CB), .ROW_BITS(RB)) bus ();

  nand_page_address_counter #(.PAGE_SIZE(2112), .COL_BITS(CB), .ROW_BITS(RB)) dut (
    .clk2   (clk2),
    .NReset (NReset),
    .bus    (bus.slave)
  );

  // Model: a run is "n bytes consumed out of len*pages"; addresses follow from n.
  bit          m_active = 1'b0;
  longint      m_n = 0, m_len = 1, m_total = 1;
  logic [11:0] m_sc = '0, m_ec = '0;
  logic [16:0] m_sr = '0, m_er = '0;
  bit          m_pd = 1'b0;
  bit          m_cfg_err = 1'b0;

  function automatic bit m_busy();
    return m_active && (m_n < m_total);
  endfunction

  function automatic bit cfg_bad(input logic [11:0] sc, input logic [11:0] ec,
                                 input logic [16:0] sr, input logic [16:0] er);
`ifdef ADDR_RANGE_CHECK_EN
    return (sc > ec) || (ec >= 12'd2112) || (sr > er);
`else
    return (sc === 12'hxxx) && (ec === 12'hxxx) && (sr === er) && 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_active  = 1'b0;
    m_pd      = 1'b0;
    m_cfg_err = 1'b0;
  endtask

  task automatic model_edge(input bit c, input bit l, input bit e);
    if (!NReset) begin
      m_reset();
    end else if (c) begin
      m_active  = 1'b0;
      m_pd      = 1'b0;
      m_cfg_err = 1'b0;
    end else if (l && !m_busy()) begin
      m_pd = 1'b0;
      if (cfg_bad(bus.start_col, bus.end_col, bus.start_row, bus.end_row)) begin
        m_cfg_err = 1'b1;
      end else begin
        m_sc      = bus.start_col;
        m_ec      = bus.end_col;
        m_sr      = bus.start_row;
        m_er      = bus.end_row;
        m_len     = ((longint'(m_ec) - longint'(m_sc) + 64'd4096) % 64'd4096) + 64'd1;
        m_total   = m_len * (((longint'(m_er) - longint'(m_sr) + 64'd131072) % 64'd131072) + 64'd1);
        m_n       = 0;
        m_active  = 1'b1;
        m_cfg_err = 1'b0;
      end
    end else if (m_busy() && e) begin
      m_n  = m_n + 1;
      m_pd = ((m_n % m_len) == 0);
    end else begin
      m_pd = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk2) begin
    longint p, e_col, e_row;
    bit     e_busy, e_xd, e_cr;
    if (m_active) begin
      p      = (m_n < m_total) ? m_n : m_total - 1;
      e_col  = (longint'(m_sc) + (p % m_len)) % 64'd4096;
      e_row  = (longint'(m_sr) + (p / m_len)) % 64'd131072;
      e_busy = (m_n < m_total);
      e_xd   = (m_n == m_total);
      e_cr   = e_busy && (e_col == longint'(m_ec));
    end else begin
      e_col = 0; e_row = 0; e_busy = 1'b0; e_xd = 1'b0; e_cr = 1'b0;
    end
    chk("col_addr",    32'(bus.col_addr),    32'(e_col));
    chk("row_addr",    32'(bus.row_addr),    32'(e_row));
    chk("busy",        32'(bus.busy),        32'(e_busy));
    chk("xfer_done",   32'(bus.xfer_done),   32'(e_xd));
    chk("page_done",   32'(bus.page_done),   32'(m_pd));
    chk("col_reached", 32'(bus.col_reached), 32'(e_cr));
`ifdef ADDR_RANGE_CHECK_EN
    chk("cfg_err",     32'(bus.cfg_err),     32'(m_cfg_err));
`endif
  end

  task automatic cyc(input bit c, input bit l, input bit e);
    bus.clear = c; bus.load = l; bus.count_enable = e;
    @(posedge clk2);
    model_edge(c, l, e);
    #1;
  endtask

  task automatic set_cfg(input int sc, input int ec, input int sr, input int er);
    bus.start_col = 12'(sc); bus.end_col = 12'(ec);
    bus.start_row = 17'(sr); bus.end_row = 17'(er);
  endtask

  initial begin
    int pd_count;
    int exp_rows [4] = '{1, 2, 3, 3};
    bus.clear = 1'b0; bus.load = 1'b0; bus.count_enable = 1'b0;
    set_cfg(0, 0, 0, 0);
    #2;

    // 1: reset held, enable toggling
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'(i % 2));
    chk("rst_col", 32'(bus.col_addr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    NReset = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);

    // 2: one full page, rows 5..5
    set_cfg(0, 2111, 5, 5);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t2_busy_after_load", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 2111; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("t2_col_2111", 32'(bus.col_addr), 32'd2111);
    chk("t2_col_reached", 32'(bus.col_reached), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t2_page_done", 32'(bus.page_done), 32'd1);
    chk("t2_xfer_done", 32'(bus.xfer_done), 32'd1);
    chk("t2_row_hold", 32'(bus.row_addr), 32'd5);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t2_done_col_hold", 32'(bus.col_addr), 32'd2111);
    chk("t2_done_pd_low", 32'(bus.page_done), 32'd0);

    // 3: three 64-byte pages at 50% enable duty
    set_cfg(2048, 2111, 10, 12);
    cyc(1'b0, 1'b1, 1'b0);
    pd_count = 0;
    for (int i = 0; i < 384; i++) begin
      cyc(1'b0, 1'b0, 1'((i % 2) == 0));
      pd_count += int'(bus.page_done);
      if (i == 126) begin
        chk("t3_row_11", 32'(bus.row_addr), 32'd11);
        chk("t3_col_wrap", 32'(bus.col_addr), 32'd2048);
      end
    end
    chk("t3_page_pulses", 32'(pd_count), 32'd3);
    chk("t3_xfer_done", 32'(bus.xfer_done), 32'd1);
    chk("t3_row_12", 32'(bus.row_addr), 32'd12);

    // 4: single-column pages
    set_cfg(7, 7, 0, 3);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t4_col_7", 32'(bus.col_addr), 32'd7);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("t4_row_step", 32'(bus.row_addr), 32'(exp_rows[k]));
    end
    chk("t4_xfer_done", 32'(bus.xfer_done), 32'd1);

    // Row wrap past 2^ROW_BITS (rejected when range checking is on)
    set_cfg(0, 0, 131071, 1);
    cyc(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1);
`ifndef ADDR_RANGE_CHECK_EN
    chk("wrap_row_1", 32'(bus.row_addr), 32'd1);
`endif

    // Load while running is ignored; enable still counts
    set_cfg(0, 9, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1);
    set_cfg(500, 600, 7, 7);
    cyc(1'b0, 1'b1, 1'b1);
    chk("run_load_ignored", 32'(bus.col_addr), 32'd4);

    // 5: clear and load on the same edge mid-run
    cyc(1'b1, 1'b1, 1'b1);
    chk("t5_clear_col", 32'(bus.col_addr), 32'd0);
    chk("t5_clear_busy", 32'(bus.busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);

    // 5: asynchronous reset at column 100
    set_cfg(0, 2111, 3, 4);
    cyc(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 100; k++) cyc(1'b0, 1'b0, 1'b1);
    chk("t5_col_100", 32'(bus.col_addr), 32'd100);
    #1;
    NReset = 1'b0;
    m_reset();
    #1;
    chk("t5_async_col", 32'(bus.col_addr), 32'd0);
    chk("t5_async_xd", 32'(bus.xfer_done), 32'd0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1);
    NReset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

`ifdef ADDR_RANGE_CHECK_EN
    // 6: out-of-page end_col rejected, then a valid load accepted
    set_cfg(0, 2112, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t6_cfg_err_set", 32'(bus.cfg_err), 32'd1);
    chk("t6_busy_low", 32'(bus.busy), 32'd0);
    set_cfg(0, 5, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t6_cfg_err_clr", 32'(bus.cfg_err), 32'd0);
    chk("t6_busy_high", 32'(bus.busy), 32'd1);
`endif

    cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk2);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
